// File: rtl/cmd_loader.sv
// Byte-stream command loader: parses A5-framed word streams into command memory
// and holds the core until a frame is loaded with a good checksum.
module cmd_loader (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        mem_we,
    output logic [11:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        core_hold,
    output logic        done,
    output logic        err,
    output logic [12:0] words_loaded
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  lo_q, lo_d;
    logic [12:0] len_q, len_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [23:0] word_q, word_d;
    logic [7:0]  xor_q, xor_d;
    logic [12:0] words_q, words_d;
    logic        mem_we_q, mem_we_d;
    logic [11:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [15:0] len_n;

    assign len_n = {rx_data, lo_q};

    always_comb begin
        state_d     = state_q;
        lo_d        = lo_q;
        len_d       = len_q;
        byte_cnt_d  = byte_cnt_q;
        word_d      = word_q;
        xor_d       = xor_q;
        words_d     = words_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if (rx_valid) begin
            unique case (state_q)
                S_IDLE, S_DONE, S_ERR: begin
                    if (rx_data == 8'hA5) begin
                        state_d    = S_LEN_LO;
                        words_d    = 13'd0;
                        xor_d      = 8'h00;
                        byte_cnt_d = 2'd0;
                    end
                end
                S_LEN_LO: begin
                    lo_d    = rx_data;
                    state_d = S_LEN_HI;
                end
                S_LEN_HI: begin
                    len_d = len_n[12:0];
                    if (len_n == 16'd0 || len_n > 16'd4096)
                        state_d = S_ERR;
                    else
                        state_d = S_DATA;
                end
                S_DATA: begin
                    xor_d      = xor_q ^ rx_data;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    unique case (byte_cnt_q)
                        2'd0: word_d[7:0]   = rx_data;
                        2'd1: word_d[15:8]  = rx_data;
                        2'd2: word_d[23:16] = rx_data;
                        2'd3: begin
                            mem_we_d    = 1'b1;
                            mem_addr_d  = words_q[11:0];
                            mem_wdata_d = {rx_data, word_q};
                            words_d     = words_q + 13'd1;
                            if (words_q == len_q - 13'd1)
                                state_d = S_CSUM;
                        end
                    endcase
                end
                S_CSUM: begin
                    state_d = (rx_data == xor_q) ? S_DONE : S_ERR;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Reset wins over a byte accepted in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            lo_q        <= 8'h00;
            len_q       <= 13'd0;
            byte_cnt_q  <= 2'd0;
            word_q      <= 24'h0;
            xor_q       <= 8'h00;
            words_q     <= 13'd0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 12'd0;
            mem_wdata_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            lo_q        <= lo_d;
            len_q       <= len_d;
            byte_cnt_q  <= byte_cnt_d;
            word_q      <= word_d;
            xor_q       <= xor_d;
            words_q     <= words_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign rx_ready     = 1'b1;
    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign words_loaded = words_q;
    assign core_hold    = (state_q != S_DONE);
    assign done         = (state_q == S_DONE);
    assign err          = (state_q == S_ERR);

endmodule

// File: tb/tb_cmd_loader.sv
// Directed testbench for cmd_loader: frame parsing, aborts, reset, reload.
module tb_cmd_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic        mem_we;
    logic [11:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        core_hold;
    logic        done;
    logic        err;
    logic [12:0] words_loaded;

    int checks = 0;
    int passed = 0;

    typedef struct {
        logic [11:0] a;
        logic [31:0] d;
    } wr_t;
    wr_t log_q[$];

    cmd_loader dut (
        .clk(clk),
        .reset(reset),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .rx_ready(rx_ready),
        .mem_we(mem_we),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .core_hold(core_hold),
        .done(done),
        .err(err),
        .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            wr_t w;
            w.a = mem_addr;
            w.d = mem_wdata;
            log_q.push_back(w);
        end
    end

    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        rx_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [31:0] w);
        send(w[7:0]);
        send(w[15:8]);
        send(w[23:16]);
        send(w[31:24]);
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h", name, act, exp);
        else
            passed++;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        chk("rst_core_hold", 32'(core_hold), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_words", 32'(words_loaded), 32'd0);
        chk("rst_rx_ready", 32'(rx_ready), 32'd1);
    endtask

    task automatic test_good_frame;
        log_q.delete();
        send(8'hA5);
        chk("good_hold_mid", 32'(core_hold), 32'd1);
        send(8'h02);
        send(8'h00);
        send_word(32'h0000_0001);
        send_word(32'h0000_0002);
        send(8'h03);
        chk("good_nwr", log_q.size(), 32'd2);
        if (log_q.size() == 2) begin
            chk("good_a0", 32'(log_q[0].a), 32'd0);
            chk("good_d0", log_q[0].d, 32'h1);
            chk("good_a1", 32'(log_q[1].a), 32'd1);
            chk("good_d1", log_q[1].d, 32'h2);
        end
        chk("good_done", 32'(done), 32'd1);
        chk("good_err", 32'(err), 32'd0);
        chk("good_hold", 32'(core_hold), 32'd0);
        chk("good_words", 32'(words_loaded), 32'd2);
    endtask

    task automatic test_bad_csum;
        log_q.delete();
        send(8'hA5);
        chk("csum_done_clr", 32'(done), 32'd0);
        send(8'h01);
        send(8'h00);
        send_word(32'h1234_5678);
        send(8'h00);
        chk("csum_nwr", log_q.size(), 32'd1);
        if (log_q.size() == 1) begin
            chk("csum_a0", 32'(log_q[0].a), 32'd0);
            chk("csum_d0", log_q[0].d, 32'h1234_5678);
        end
        chk("csum_err", 32'(err), 32'd1);
        chk("csum_done", 32'(done), 32'd0);
        chk("csum_hold", 32'(core_hold), 32'd1);
        idle(2);
        chk("csum_addr_hold", 32'(mem_addr), 32'd0);
        chk("csum_wdata_hold", mem_wdata, 32'h1234_5678);
    endtask

    task automatic test_bad_len;
        log_q.delete();
        send(8'hA5);
        chk("len0_err_clr", 32'(err), 32'd0);
        send(8'h00);
        send(8'h00);
        chk("len0_err", 32'(err), 32'd1);
        send(8'hA5);
        send(8'h01);
        send(8'h10);
        chk("len4097_err", 32'(err), 32'd1);
        idle(3);
        chk("badlen_nwr", log_q.size(), 32'd0);
    endtask

    task automatic test_garbage;
        log_q.delete();
        send(8'h00);
        send(8'hFF);
        send(8'h5A);
        chk("garb_err_kept", 32'(err), 32'd1);
        rx_data = 8'hA5;
        idle(3);
        chk("novalid_ignored", 32'(err), 32'd1);
        send(8'hA5);
        send(8'h01);
        send(8'h00);
        send_word(32'hDEAD_BEEF);
        send(8'h22);
        chk("garb_done", 32'(done), 32'd1);
        chk("garb_words", 32'(words_loaded), 32'd1);
        chk("garb_nwr", log_q.size(), 32'd1);
        if (log_q.size() == 1)
            chk("garb_d0", log_q[0].d, 32'hDEAD_BEEF);
    endtask

    task automatic test_reset_mid;
        log_q.delete();
        send(8'hA5);
        send(8'h02);
        send(8'h00);
        send_word(32'h4433_2211);
        send(8'h55);
        send(8'h66);
        reset    = 1'b1;
        rx_data  = 8'h77;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        reset    = 1'b0;
        rx_valid = 1'b0;
        chk("mid_hold", 32'(core_hold), 32'd1);
        chk("mid_done", 32'(done), 32'd0);
        chk("mid_err", 32'(err), 32'd0);
        chk("mid_we", 32'(mem_we), 32'd0);
        chk("mid_addr", 32'(mem_addr), 32'd0);
        chk("mid_wdata", mem_wdata, 32'd0);
        chk("mid_words", 32'(words_loaded), 32'd0);
        send(8'h77);
        send(8'h88);
        idle(2);
        chk("mid_nwr", log_q.size(), 32'd1);
        send(8'hA5);
        send(8'h01);
        send(8'h00);
        send_word(32'h0403_0201);
        send(8'h04);
        chk("mid_fresh_done", 32'(done), 32'd1);
        chk("mid_fresh_nwr", log_q.size(), 32'd2);
        if (log_q.size() == 2) begin
            chk("mid_fresh_a", 32'(log_q[1].a), 32'd0);
            chk("mid_fresh_d", log_q[1].d, 32'h0403_0201);
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0]  x;
        logic [31:0] w;
        int          bad;
        log_q.delete();
        x = 8'h00;
        send(8'hA5);
        send(8'h00);
        send(8'h10);
        for (int i = 0; i < 4096; i++) begin
            w = {~i[7:0], 8'h5A, 4'h0, i[11:8], i[7:0]};
            x = x ^ w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
            send_word(w);
        end
        send(x);
        chk("b2b_nwr", log_q.size(), 32'd4096);
        bad = 0;
        if (log_q.size() == 4096) begin
            for (int i = 0; i < 4096; i++) begin
                w = {~i[7:0], 8'h5A, 4'h0, i[11:8], i[7:0]};
                if (log_q[i].a !== i[11:0] || log_q[i].d !== w) bad++;
            end
        end
        chk("b2b_bad_writes", bad, 32'd0);
        chk("b2b_done", 32'(done), 32'd1);
        chk("b2b_hold", 32'(core_hold), 32'd0);
        chk("b2b_words", 32'(words_loaded), 32'd4096);
        send(8'hA5);
        chk("reload_hold", 32'(core_hold), 32'd1);
        chk("reload_done", 32'(done), 32'd0);
        chk("reload_words", 32'(words_loaded), 32'd0);
    endtask

    initial begin
        @(posedge clk);
        #1;
        test_reset;
        test_good_frame;
        test_bad_csum;
        test_bad_len;
        test_garbage;
        test_reset_mid;
        test_back_to_back;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
